// File: rtl/i2c_codec_sequencer.sv
// Sequencer that feeds the I2C bit engine a fixed table of codec register writes,
// one START/address/two-byte/STOP transaction per entry, with NACK retries.
module i2c_codec_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 11,
  parameter int         RETRY_MAX = 3
) (
  input  logic       inClock,
  input  logic       reset,
  input  logic       start,
  input  logic       ready,
  input  logic       ack,
  output logic       en,
  output logic [1:0] mode,
  output logic [7:0] outData,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] entry
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);
  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

  localparam logic [1:0] M_START = 2'd0;
  localparam logic [1:0] M_BYTE  = 2'd1;
  localparam logic [1:0] M_STOP  = 2'd2;

  typedef enum logic [3:0] {
    IDLE, S_START, S_ADDR, S_B1, S_B2, S_STOP, NEXT, DONE, ERROR
  } state_t;

  state_t        state;
  logic [RW-1:0] retries;
  logic          nack_flag;
  logic          armed;
  logic [15:0]   word_reg;
  logic [15:0]   rom_tbl [16];

  // Table words are {reg[6:0], data[8:0]}; BYTE1 is word[15:8], BYTE2 is word[7:0].
  function automatic logic [15:0] table_word(input int idx);
    case (idx)
      0:       table_word = {7'd15, 9'h000};
      1:       table_word = {7'd0,  9'h017};
      2:       table_word = {7'd1,  9'h017};
      3:       table_word = {7'd2,  9'h079};
      4:       table_word = {7'd3,  9'h079};
      5:       table_word = {7'd4,  9'h012};
      6:       table_word = {7'd5,  9'h000};
      7:       table_word = {7'd6,  9'h000};
      8:       table_word = {7'd7,  9'h002};
      9:       table_word = {7'd8,  9'h000};
      10:      table_word = {7'd9,  9'h001};
      default: table_word = 16'h0000;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rom
      assign rom_tbl[gi] = table_word(gi);
    end
  endgenerate

  // Registered ROM read; entry is stable for several cycles before BYTE1 is needed.
  always_ff @(posedge inClock) begin
    word_reg <= rom_tbl[entry];
  end

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      en        <= 1'b0;
      mode      <= M_START;
      outData   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      entry     <= 4'd0;
      retries   <= '0;
      nack_flag <= 1'b0;
      armed     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= S_START;
            en        <= 1'b1;
            mode      <= M_START;
            outData   <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            entry     <= 4'd0;
            retries   <= '0;
            nack_flag <= 1'b0;
            armed     <= 1'b0;
          end
        end

        S_START, S_ADDR, S_B1, S_B2, S_STOP: begin
          // A ready that never went low belongs to the previous phase.
          if (!ready) armed <= 1'b1;
          if (ready && armed) begin
            armed <= 1'b0;
            case (state)
              S_START: begin
                state   <= S_ADDR;
                mode    <= M_BYTE;
                outData <= {DEV_ADDR, 1'b0};
              end
              S_ADDR, S_B1: begin
                if (ack) begin
                  state   <= (state == S_ADDR) ? S_B1 : S_B2;
                  mode    <= M_BYTE;
                  outData <= (state == S_ADDR) ? word_reg[15:8] : word_reg[7:0];
                end else begin
                  state     <= S_STOP;
                  mode      <= M_STOP;
                  outData   <= 8'h00;
                  nack_flag <= 1'b1;
                end
              end
              S_B2: begin
                state     <= S_STOP;
                mode      <= M_STOP;
                outData   <= 8'h00;
                nack_flag <= ~ack;
              end
              S_STOP: begin
                if (!nack_flag) begin
                  state <= NEXT;
                end else if (retries < RMAX) begin
                  retries   <= retries + 1'b1;
                  nack_flag <= 1'b0;
                  state     <= S_START;
                  mode      <= M_START;
                end else begin
                  state <= ERROR;
                  en    <= 1'b0;
                  busy  <= 1'b0;
                  error <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end

        NEXT: begin
          if (entry == LAST) begin
            state <= DONE;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            entry   <= entry + 4'd1;
            retries <= '0;
            state   <= S_START;
            mode    <= M_START;
            outData <= 8'h00;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_codec_sequencer.md
# i2c_codec_sequencer

- Upstream command source for the I2C bit engine.
- Walks a fixed table of audio-codec (WM8731-style) register writes. For each entry it issues one I2C write transaction: START, device-address byte, two data bytes, STOP.
- Drives the engine's `en`/`mode`/`inData` inputs and consumes its `ready`/`ack` outputs.
- Retries NACKed transactions and reports completion or failure to the top-level control logic.

## Interface
Parameters:
- `DEV_ADDR`, 7'h1A: 7-bit codec slave address. Write bit is 0, so address byte = {`DEV_ADDR`, 1'b0}.
- `NUM_REGS`, 11: number of table entries used (max 16).
- `RETRY_MAX`, 3: retries per entry after a NACK, before declaring error.

Ports:
- `inClock`  in  1  system clock. Same clock as the bit engine.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins the sequence at entry 0.
- `ready`  in  1  engine phase-complete flag. Level; held until the engine starts its next phase.
- `ack`  in  1  engine ack result; valid when `ready`=1 after a byte phase.
- `en`  out  1  engine enable.
- `mode`  out  2  engine command: 0=START, 1=BYTE, 2=STOP.
- `outData`  out  8  byte to transmit; connects to engine `inData`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  all entries written. Level.
- `error`  out  1  retries exhausted. Level.
- `entry`  out  4  current table index.

## Operation
Table:
- Internal ROM of 16-bit words {reg[6:0], data[8:0]}.
- Entries 0..10: R15=0x000, R0=0x017, R1=0x017, R2=0x079, R3=0x079, R4=0x012, R5=0x000, R6=0x000, R7=0x002, R8=0x000, R9=0x001.
- Data bytes per entry: BYTE1 = {reg[6:0], data[8]}, BYTE2 = data[7:0].

States:
- IDLE: `en`=0. On `start` → S_START.
- S_START: `mode`=0.
- S_ADDR: `mode`=1, `outData`={`DEV_ADDR`,0}.
- S_B1: `mode`=1, `outData`=BYTE1.
- S_B2: `mode`=1, `outData`=BYTE2.
- S_STOP: `mode`=2.
- NEXT
- DONE
- ERROR

Phase completion rule:
- Each phase state owns an `armed` flag, cleared on entry and set once `ready`=0 is seen.
- The phase completes on a clock edge where `ready`=1 and `armed`=1.
- This ignores the stale `ready` left over from the previous phase.

Transitions on phase completion:
- S_START → S_ADDR.
- S_ADDR → S_B1, S_B1 → S_B2, S_B2 → S_STOP; each only if `ack`=1.
- Any byte phase with `ack`=0 sets `nack_flag` and goes to S_STOP, skipping the remaining bytes.
- S_STOP with `nack_flag`=0 → NEXT.
- S_STOP with `nack_flag`=1:
  - `retries` < `RETRY_MAX`: `retries`+1, clear `nack_flag`, → S_START with the same entry.
  - Otherwise → ERROR.

NEXT (1 cycle):
- If `entry`=`NUM_REGS`-1 → DONE.
- Else `entry`+1, `retries`=0 → S_START.

Outputs and flags:
- `en`=1 in S_START..S_STOP and NEXT; 0 in IDLE, DONE, ERROR.
- `mode`/`outData` are registered and stable for the whole phase state.
- `busy`=1 from the edge after `start` until DONE or ERROR is entered.
- DONE and ERROR are held. `start` there clears `done`/`error`, sets `entry`=0 and `retries`=0, and → S_START.
- `start` while `busy` is ignored.

## Timing
- Reset values: `en`=0, `mode`=0, `outData`=8'h00, `busy`=0, `done`=0, `error`=0, `entry`=0. Internally `retries`=0, `nack_flag`=0, state IDLE.
- Reset mid-transaction: immediate return to IDLE. No STOP is issued (the engine is reset by the same line and releases the bus). Restart requires a new `start`.
- `start` → `en`=1, `mode`=0 on the next edge. Latency 1 cycle.
- Phase-to-phase: the new `mode`/`outData` appear on the edge that samples qualified `ready`. No idle cycle between phases.
- `retries` width: $clog2(`RETRY_MAX`+1) bits, saturating compare. `entry` wraps never; bounded by `NUM_REGS`-1.
- `ack` is only sampled together with qualified `ready`. `ack` at other times is ignored.

## Test plan
- **Full sequence** (behavioural engine model: `ready` low 3 cycles after a mode change, then high; `ack`=1):
  - 11 transactions are produced.
  - Bytes per transaction are 0x34, then BYTE1/BYTE2 of each entry (entry 0: 0x1E,0x00; entry 10: 0x12,0x01).
  - `done`=1, `busy`=0, `entry`=10.
- **Stale ready:** hold `ready`=1 across a mode change for 2 cycles → the sequencer must not advance until `ready` drops and rises again.
- **Single NACK:** `ack`=0 on entry 4 BYTE1 → BYTE2 is skipped, STOP, entry 4 is retried in full, then the sequence completes normally.
- **Retries exhausted:** `ack`=0 on every attempt of entry 2 with `RETRY_MAX`=3 → 4 START/STOP pairs, then `error`=1, `busy`=0, `en`=0, `entry`=2.
- **Reset mid-transaction:** assert `reset` during entry 6 S_B2 → all outputs return to reset values; a later `start` begins at entry 0.
- **Start handling:**
  - `start` while `busy` → no effect.
  - `start` in ERROR → clears `error`, restarts from entry 0.
